// File: rtl/hsync_timing_gen_if.sv
// Horizontal timing bundle between the line generator and its consumers.
// The consumer side drives enable; everything else flows generator -> consumer.
interface hsync_timing_gen_if #(
    parameter int HPIX_W = 7,
    parameter int HCNT_W = 10
);
    logic              enable;
    logic              hsync;
    logic [HPIX_W-1:0] hpixel;
    logic              display_time;
    logic [HCNT_W-1:0] hcount;
    logic              pixel_tick;
    logic              line_start;

    modport master (
        input  enable,
        output hsync, hpixel, display_time, hcount, pixel_tick, line_start
    );

    modport slave (
        output enable,
        input  hsync, hpixel, display_time, hcount, pixel_tick, line_start
    );
endinterface

// File: rtl/hsync_timing_gen.sv
// Purpose: parametrised horizontal VGA timing (divider + ACTIVE/FRONT/SYNC/BACK FSM).
// Latency: timing outputs update one clk after pixel_tick; enable=0 freezes all state.
// Backpressure: none; enable is the only stall and it holds every output except the strobes.
module hsync_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int PIX_REP  = 5,
    parameter int HPIX_W   = 7,
    parameter int HCNT_W   = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    hsync_timing_gen_if.master  tm
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REP_W   = (PIX_REP > 1) ? $clog2(PIX_REP) : 1;
    localparam int SEG_MAX_AF = (H_ACTIVE > H_FP) ? H_ACTIVE : H_FP;
    localparam int SEG_MAX_SB = (H_SYNC > H_BP) ? H_SYNC : H_BP;
    localparam int SEG_MAX    = (SEG_MAX_AF > SEG_MAX_SB) ? SEG_MAX_AF : SEG_MAX_SB;
    localparam int SEG_W      = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(PIX_REP - 1);
    localparam logic [HCNT_W-1:0] HC_LAST   = HCNT_W'(H_TOTAL - 1);
    localparam logic [SEG_W-1:0]  LAST_ACT  = SEG_W'(H_ACTIVE - 1);
    localparam logic [SEG_W-1:0]  LAST_FP   = SEG_W'(H_FP - 1);
    localparam logic [SEG_W-1:0]  LAST_SYNC = SEG_W'(H_SYNC - 1);
    localparam logic [SEG_W-1:0]  LAST_BP   = SEG_W'(H_BP - 1);
    localparam logic [HPIX_W-1:0] HPIX_MAX  = {HPIX_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [SEG_W-1:0]    seg_cnt, seg_nxt;
    logic [DIV_W-1:0]    div_cnt, div_wrap;
    logic [REP_W-1:0]    rep_cnt, rep_nxt;
    logic [HCNT_W-1:0]   hcount_r, hcount_nxt;
    logic [HPIX_W-1:0]   hpixel_r, hpixel_nxt;
    logic                pixel_tick_r;
    logic                line_start_r;
    logic                display_time_r;
    logic                hsync_r;
    logic                seg_last;
    logic                advance;

    assign advance  = tm.enable & pixel_tick_r;
    assign div_wrap = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

    // A tick frozen by enable=0 leaves div_cnt parked on DIV_LAST with the
    // strobe cleared; re-raising the strobe there keeps that tick from being lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            pixel_tick_r <= 1'b0;
        end else if (!tm.enable) begin
            pixel_tick_r <= 1'b0;
        end else if ((div_cnt == DIV_LAST) && !pixel_tick_r) begin
            pixel_tick_r <= 1'b1;
        end else begin
            div_cnt      <= div_wrap;
            pixel_tick_r <= (div_wrap == DIV_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_BACK;
            seg_cnt <= LAST_BP;
        end else if (advance) begin
            state   <= state_nxt;
            seg_cnt <= seg_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        seg_nxt    = seg_cnt + SEG_W'(1);
        seg_last   = 1'b0;
        rep_nxt    = '0;
        hpixel_nxt = '0;
        hcount_nxt = (hcount_r == HC_LAST) ? '0 : hcount_r + HCNT_W'(1);

        case (state)
            ST_ACTIVE: seg_last = (seg_cnt == LAST_ACT);
            ST_FRONT:  seg_last = (seg_cnt == LAST_FP);
            ST_SYNC:   seg_last = (seg_cnt == LAST_SYNC);
            default:   seg_last = (seg_cnt == LAST_BP);
        endcase

        if (seg_last) begin
            seg_nxt = '0;
            case (state)
                ST_ACTIVE: state_nxt = ST_FRONT;
                ST_FRONT:  state_nxt = ST_SYNC;
                ST_SYNC:   state_nxt = ST_BACK;
                default:   state_nxt = ST_ACTIVE;
            endcase
        end

        // Entering or leaving ACTIVE clears the replication state; only a
        // tick that stays inside ACTIVE advances it.
        if ((state == ST_ACTIVE) && (state_nxt == ST_ACTIVE)) begin
            if (rep_cnt == REP_LAST) begin
                rep_nxt    = '0;
                hpixel_nxt = (hpixel_r == HPIX_MAX) ? hpixel_r : hpixel_r + HPIX_W'(1);
            end else begin
                rep_nxt    = rep_cnt + REP_W'(1);
                hpixel_nxt = hpixel_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_r       <= HC_LAST;
            rep_cnt        <= '0;
            hpixel_r       <= '0;
            display_time_r <= 1'b0;
            hsync_r        <= ~SYNC_POL;
            line_start_r   <= 1'b0;
        end else if (advance) begin
            hcount_r       <= hcount_nxt;
            rep_cnt        <= rep_nxt;
            hpixel_r       <= hpixel_nxt;
            display_time_r <= (state_nxt == ST_ACTIVE);
            hsync_r        <= (state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            line_start_r   <= (hcount_nxt == '0);
        end else begin
            line_start_r   <= 1'b0;
        end
    end

    assign tm.hsync        = hsync_r;
    assign tm.hpixel       = hpixel_r;
    assign tm.display_time = display_time_r;
    assign tm.hcount       = hcount_r;
    assign tm.pixel_tick   = pixel_tick_r;
    assign tm.line_start   = line_start_r;

endmodule

// File: tb/tb_hsync_timing_gen.sv
// Directed bench: default timing, a tiny 8-tick line, hpixel saturation, freeze and mid-line reset.
module tb_hsync_timing_gen;

    logic clk = 1'b0;
    logic reset;
    int   applied = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    hsync_timing_gen_if                           if0 ();
    hsync_timing_gen_if #(.HPIX_W(1), .HCNT_W(3)) if1 ();
    hsync_timing_gen_if                           if2 ();

    hsync_timing_gen u0 (.clk(clk), .reset(reset), .tm(if0));

    hsync_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .PIX_REP(2), .HPIX_W(1), .HCNT_W(3), .SYNC_POL(1'b1)
    ) u1 (.clk(clk), .reset(reset), .tm(if1));

    hsync_timing_gen #(.PIX_REP(4)) u2 (.clk(clk), .reset(reset), .tm(if2));

    typedef struct {
        logic       dt;
        logic       hs;
        logic       hp;
        logic [2:0] hc;
        logic       ls;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_u0(input string p);
        chk({p, "_rst_hcount"}, 32'(if0.hcount), 799);
        chk({p, "_rst_dt"},     32'(if0.display_time), 0);
        chk({p, "_rst_hpixel"}, 32'(if0.hpixel), 0);
        chk({p, "_rst_hsync"},  32'(if0.hsync), 1);
        chk({p, "_rst_pt"},     32'(if0.pixel_tick), 0);
        chk({p, "_rst_ls"},     32'(if0.line_start), 0);
    endtask

    // Called on the negedge where reset has just been dropped.
    task automatic recovery_u0(input string p);
        @(negedge clk); chk({p, "_pt_c1"}, 32'(if0.pixel_tick), 0);
        @(negedge clk); chk({p, "_pt_c2"}, 32'(if0.pixel_tick), 0);
        @(negedge clk); chk({p, "_pt_c3"}, 32'(if0.pixel_tick), 1);
        chk({p, "_dt_c3"}, 32'(if0.display_time), 0);
        @(negedge clk);
        chk({p, "_ls_c4"},  32'(if0.line_start), 1);
        chk({p, "_dt_c4"},  32'(if0.display_time), 1);
        chk({p, "_hc_c4"},  32'(if0.hcount), 0);
        chk({p, "_hp_c4"},  32'(if0.hpixel), 0);
        chk({p, "_hs_c4"},  32'(if0.hsync), 1);
        @(negedge clk); chk({p, "_ls_c5"}, 32'(if0.line_start), 0);
    endtask

    task automatic full_line_u0();
        int n = 0, exp_hc = 0, exp_hp;
        int bad_hc = 0, bad_dt = 0, bad_hs = 0, bad_hp = 0;
        int ls_cnt = 0, ls_at = -1, dt_cyc = 0, hs_cyc = 0;
        int hp634 = -1, hp635 = -1, hp640 = -1;
        logic prev_pt;
        while (n < 3300 && !if0.line_start) begin @(negedge clk); n++; end
        chk("u0_line_ls_seen", 32'(if0.line_start), 1);
        prev_pt = if0.pixel_tick;
        for (int c = 1; c <= 3200; c++) begin
            @(negedge clk);
            if (prev_pt) exp_hc = (exp_hc + 1) % 800;
            prev_pt = if0.pixel_tick;
            exp_hp  = (exp_hc < 640) ? ((exp_hc / 5 > 127) ? 127 : exp_hc / 5) : 0;
            if (int'(if0.hcount) != exp_hc) bad_hc++;
            if (if0.display_time !== (exp_hc < 640)) bad_dt++;
            if (if0.hsync !== !(exp_hc >= 656 && exp_hc <= 751)) bad_hs++;
            if (int'(if0.hpixel) != exp_hp) bad_hp++;
            if (if0.line_start) begin ls_cnt++; ls_at = c; end
            if (if0.display_time) dt_cyc++;
            if (!if0.hsync) hs_cyc++;
            if (exp_hc == 634) hp634 = int'(if0.hpixel);
            if (exp_hc == 635) hp635 = int'(if0.hpixel);
            if (exp_hc == 640) hp640 = int'(if0.hpixel);
        end
        chk("u0_hcount_track", bad_hc, 0);
        chk("u0_dt_track",     bad_dt, 0);
        chk("u0_hsync_track",  bad_hs, 0);
        chk("u0_hpixel_track", bad_hp, 0);
        chk("u0_ls_count",     ls_cnt, 1);
        chk("u0_ls_period",    ls_at, 3200);
        chk("u0_dt_cycles",    dt_cyc, 2560);
        chk("u0_hsync_cycles", hs_cyc, 384);
        chk("u0_hp_at_634",    hp634, 126);
        chk("u0_hp_at_635",    hp635, 127);
        chk("u0_hp_at_640",    hp640, 0);
    endtask

    task automatic small_line_u1();
        int n = 0;
        while (n < 20 && !if1.line_start) begin @(negedge clk); n++; end
        chk("u1_ls_seen", 32'(if1.line_start), 1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("u1_dt_%0d", i), 32'(if1.display_time), 32'(tbl[i % 8].dt));
            chk($sformatf("u1_hs_%0d", i), 32'(if1.hsync),        32'(tbl[i % 8].hs));
            chk($sformatf("u1_hp_%0d", i), 32'(if1.hpixel),       32'(tbl[i % 8].hp));
            chk($sformatf("u1_hc_%0d", i), 32'(if1.hcount),       32'(tbl[i % 8].hc));
            chk($sformatf("u1_ls_%0d", i), 32'(if1.line_start),   32'(tbl[i % 8].ls));
            chk($sformatf("u1_pt_%0d", i), 32'(if1.pixel_tick),   1);
        end
    endtask

    task automatic sat_line_u2();
        int n = 0, exp_hp, bad_hp = 0, hc;
        int hp507 = -1, hp508 = -1, hp639 = -1, hp640 = -1;
        while (n < 3300 && !if2.line_start) begin @(negedge clk); n++; end
        chk("u2_ls_seen", 32'(if2.line_start), 1);
        for (int c = 0; c < 3200; c++) begin
            if (c > 0) @(negedge clk);
            hc     = int'(if2.hcount);
            exp_hp = (hc < 640) ? ((hc / 4 > 127) ? 127 : hc / 4) : 0;
            if (int'(if2.hpixel) != exp_hp) bad_hp++;
            if (hc == 507) hp507 = int'(if2.hpixel);
            if (hc == 508) hp508 = int'(if2.hpixel);
            if (hc == 639) hp639 = int'(if2.hpixel);
            if (hc == 640) hp640 = int'(if2.hpixel);
        end
        chk("u2_hpixel_track", bad_hp, 0);
        chk("u2_hp_at_507", hp507, 126);
        chk("u2_hp_at_508", hp508, 127);
        chk("u2_hp_at_639", hp639, 127);
        chk("u2_hp_at_640", hp640, 0);
    endtask

    task automatic freeze_in_sync_u0();
        int n = 0, bad = 0, ticks = 0, last_hc = 700;
        while (n < 4000 && int'(if0.hcount) != 700) begin @(negedge clk); n++; end
        chk("frz_reach_700", 32'(if0.hcount), 700);
        chk("frz_hsync_at_700", 32'(if0.hsync), 0);
        if0.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if0.pixel_tick || if0.line_start || int'(if0.hcount) != 700 || if0.hsync) bad++;
        end
        chk("frz_hold_cycles", bad, 0);
        if0.enable = 1'b1;
        n = 0;
        while (n < 1000 && !if0.hsync) begin
            @(negedge clk); n++;
            if (!if0.hsync) begin
                last_hc = int'(if0.hcount);
                if (if0.pixel_tick) ticks++;
            end
        end
        chk("frz_sync_ended", 32'(if0.hsync), 1);
        chk("frz_last_sync_hc", last_hc, 751);
        chk("frz_first_back_hc", 32'(if0.hcount), 752);
        // 44 ticks of SYNC elapsed before hcount 700, so 52 must remain.
        chk("frz_remaining_ticks", ticks, 52);
    endtask

    initial begin
        tbl[0] = '{dt: 1'b1, hs: 1'b0, hp: 1'b0, hc: 3'd0, ls: 1'b1};
        tbl[1] = '{dt: 1'b1, hs: 1'b0, hp: 1'b0, hc: 3'd1, ls: 1'b0};
        tbl[2] = '{dt: 1'b1, hs: 1'b0, hp: 1'b1, hc: 3'd2, ls: 1'b0};
        tbl[3] = '{dt: 1'b1, hs: 1'b0, hp: 1'b1, hc: 3'd3, ls: 1'b0};
        tbl[4] = '{dt: 1'b0, hs: 1'b0, hp: 1'b0, hc: 3'd4, ls: 1'b0};
        tbl[5] = '{dt: 1'b0, hs: 1'b1, hp: 1'b0, hc: 3'd5, ls: 1'b0};
        tbl[6] = '{dt: 1'b0, hs: 1'b1, hp: 1'b0, hc: 3'd6, ls: 1'b0};
        tbl[7] = '{dt: 1'b0, hs: 1'b0, hp: 1'b0, hc: 3'd7, ls: 1'b0};

        reset      = 1'b1;
        if0.enable = 1'b1;
        if1.enable = 1'b1;
        if2.enable = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_u0("init");
        chk("init_rst_u1_hsync", 32'(if1.hsync), 0);
        chk("init_rst_u1_hcount", 32'(if1.hcount), 7);
        reset = 1'b0;

        fork
            begin
                recovery_u0("init");
                full_line_u0();
            end
            small_line_u1();
            sat_line_u2();
        join

        freeze_in_sync_u0();

        begin : midline_reset
            int n = 0;
            while (n < 4000 && int'(if0.hcount) != 300) begin @(negedge clk); n++; end
            chk("mid_reach_300", 32'(if0.hcount), 300);
            chk("mid_dt_before", 32'(if0.display_time), 1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk_reset_u0("mid");
            recovery_u0("mid");
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule

// File: doc/hsync_timing_gen.md
Name: hsync_timing_gen

Overview:
Parametrised horizontal VGA timing generator, the generalisation of the fixed-format hpixel path. It contains an internal pixel-clock divider and a four-state horizontal FSM (ACTIVE, FRONT, SYNC, BACK). It produces hsync, a scaled pixel column, display_time and line-boundary strobes for the downstream vertical counter and pixel fetch. Porch and sync lengths, clock division, pixel replication and sync polarity are set at elaboration time. A run-time enable can freeze timing.

Parameters:
CLK_DIV, 4, system clk cycles per pixel tick (>=1)
H_ACTIVE, 640, visible pixel ticks per line (>=1)
H_FP, 16, front-porch ticks (>=1)
H_SYNC, 96, sync-pulse ticks (>=1)
H_BP, 48, back-porch ticks (>=1)
PIX_REP, 5, pixel ticks per hpixel step (>=1)
HPIX_W, 7, hpixel width
HCNT_W, 10, hcount width; must hold H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
SYNC_POL, 0, active level of hsync (0 = active-low)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
enable  input  1  1 = run; 0 = freeze divider and all timing state
hsync  output  1  horizontal sync, equals SYNC_POL while in SYNC
hpixel  output  HPIX_W  scaled active column; 0 outside ACTIVE
display_time  output  1  high while in ACTIVE
hcount  output  HCNT_W  raw tick position in line, 0..H_TOTAL-1
pixel_tick  output  1  one-clk strobe per pixel period
line_start  output  1  one-clk strobe when hcount becomes 0

Behaviour:
- All outputs are registered. Reset dominates enable.
- Reset values:
  - div_cnt=0, pixel_tick=0, line_start=0.
  - state=BACK, seg_cnt=H_BP-1, hcount=H_TOTAL-1.
  - rep_cnt=0, hpixel=0, display_time=0, hsync=~SYNC_POL.
- Divider:
  - With enable=1, div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick=1 in exactly the clk cycle where div_cnt==CLK_DIV-1.
  - CLK_DIV=1: pixel_tick stays high continuously while enable=1.
- Timing registers (state, seg_cnt, hcount, rep_cnt, hpixel, hsync, display_time, line_start) update only on an edge where pixel_tick=1 and enable=1.
  - Outputs therefore change one clk after pixel_tick rises.
  - line_start is high for that single following clk cycle only.
- enable=0: div_cnt and all timing state hold. pixel_tick and line_start are forced 0. Other outputs hold their values. Counting resumes from the frozen point.
- hcount increments per tick and wraps from H_TOTAL-1 to 0. The wrap coincides with entry into ACTIVE and with line_start.
- FSM, one segment counter seg_cnt (counts up to segment length-1):
  - ACTIVE -> FRONT after H_ACTIVE ticks.
  - FRONT -> SYNC after H_FP ticks.
  - SYNC -> BACK after H_SYNC ticks.
  - BACK -> ACTIVE after H_BP ticks.
  - seg_cnt clears on every transition.
  - The first tick after reset enters ACTIVE with hcount=0.
- Outputs are registered decodes of the next state: display_time = (ACTIVE), hsync = SYNC_POL while in SYNC.
- hpixel:
  - On entry to ACTIVE: hpixel=0, rep_cnt=0.
  - Each ACTIVE tick, rep_cnt increments. When it wraps from PIX_REP-1 to 0, hpixel increments.
  - hpixel saturates at 2^HPIX_W-1; no wrap.
  - Forced 0 outside ACTIVE.
- Defaults give: hsync low for hcount 656..751; hpixel 0..127; 3200 clk cycles per line.
- Reset mid-line: the next edge loads the reset values regardless of state or enable. There is no partial pulse beyond that edge.

Test Plan:
1. Defaults, reset held 3 clk, then enable=1 -> pixel_tick first high in 4th clk after release. Next clk: display_time=1, hcount=0, line_start=1 for 1 clk, hpixel=0.
2. Defaults, full line -> display_time high for 640 ticks, hsync low exactly for hcount 656..751, line_start period 3200 clk, hpixel reaches 127 at hcount 635..639 then 0 at hcount 640.
3. CLK_DIV=1, H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, PIX_REP=2, HPIX_W=1, SYNC_POL=1.
   - Per clk after reset: display_time 1,1,1,1,0,0,0,0; hsync 0,0,0,0,0,1,1,0; hpixel 0,0,1,1,0,0,0,0.
   - Pattern repeats every 8 clk.
4. Saturation: PIX_REP=4, HPIX_W=7, H_ACTIVE=640 -> hpixel reaches 127 at hcount 508 and holds 127 through hcount 639.
5. enable pulled low for 10 clk at hcount=700 (inside SYNC) -> no pixel_tick, hcount/hsync frozen. After re-enable, the SYNC segment completes with a total of 96 ticks.
6. reset asserted for 1 clk at hcount=300 -> next clk: display_time=0, hcount=H_TOTAL-1, hpixel=0. Recovery matches scenario 1.
